// File: rtl/dp_ctrl_pkg.sv
// Shared types for the datapath control sequencer: opcodes, ALU function
// selects, FSM states and instruction field positions.
package dp_ctrl_pkg;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_ORR  = 5'd4,
    OP_EOR  = 5'd5,
    OP_ADDI = 5'd6,
    OP_SUBI = 5'd7,
    OP_LSLI = 5'd8,
    OP_LSRI = 5'd9,
    OP_MOVI = 5'd10,
    OP_ADDS = 5'd11,
    OP_SUBS = 5'd12
  } opcode_e;

  // fs[4:2] picks the ALU operation, fs[1] inverts A, fs[0] inverts B.
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam int OPC_LSB = 27;
  localparam int RD_LSB  = 22;
  localparam int RA_LSB  = 17;
  localparam int RB_LSB  = 12;
  localparam int IMM_LSB = 0;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 12;

  localparam logic [4:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [4:0] fs;
    logic       s;
    logic       c0;
    logic       force_a31;
    logic       set_flags;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/dp_ctrl_decode.sv
// Combinational opcode decoder. ADDS/SUBS are only legal when the
// DP_CTRL_SEQ_FLAGS_EN macro is defined; otherwise they decode as illegal.
import dp_ctrl_pkg::*;

module dp_ctrl_decode (
  input  opcode_e opcode_i,
  output dec_t    dec_o
);

  always_comb begin
    dec_o = '{fs: FS_ADD, s: 1'b0, c0: 1'b0, force_a31: 1'b0,
              set_flags: 1'b0, legal: 1'b1};
    case (opcode_i)
      OP_NOP:  ;
      OP_ADD:  dec_o.fs = FS_ADD;
      OP_SUB:  begin dec_o.fs = FS_SUB; dec_o.c0 = 1'b1; end
      OP_AND:  dec_o.fs = FS_AND;
      OP_ORR:  dec_o.fs = FS_OR;
      OP_EOR:  dec_o.fs = FS_XOR;
      OP_ADDI: begin dec_o.fs = FS_ADD; dec_o.s = 1'b1; end
      OP_SUBI: begin dec_o.fs = FS_SUB; dec_o.s = 1'b1; dec_o.c0 = 1'b1; end
      OP_LSLI: begin dec_o.fs = FS_LSL; dec_o.s = 1'b1; end
      OP_LSRI: begin dec_o.fs = FS_LSR; dec_o.s = 1'b1; end
      // MOVI adds the immediate to the zero register.
      OP_MOVI: begin dec_o.fs = FS_ADD; dec_o.s = 1'b1; dec_o.force_a31 = 1'b1; end
`ifdef DP_CTRL_SEQ_FLAGS_EN
      OP_ADDS: begin dec_o.fs = FS_ADD; dec_o.set_flags = 1'b1; end
      OP_SUBS: begin dec_o.fs = FS_SUB; dec_o.c0 = 1'b1; dec_o.set_flags = 1'b1; end
`endif
      default: dec_o.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_ctrl_seq.sv
// Three-state instruction sequencer driving datapath control lines.
// Optional flag latching for ADDS/SUBS is enabled by DP_CTRL_SEQ_FLAGS_EN.
import dp_ctrl_pkg::*;

module dp_ctrl_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [3:0]  status,
  output logic [4:0]  fs,
  output logic [4:0]  addrR,
  output logic [4:0]  addrA,
  output logic [4:0]  addrB,
  output logic [63:0] k,
  output logic        s,
  output logic        sd,
  output logic        sb,
  output logic        c0,
  output logic        w,
  output logic        busy,
  output logic        illegal,
  output logic [3:0]  flags
);

  // Handshake: an instruction transfers on a rising edge where instr_valid
  // and instr_ready are both high; instr_ready is high only in IDLE.

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic        illegal_q;
  dec_t        dec;
  opcode_e     opc;
  logic [4:0]  rd, ra, rb;
  logic [11:0] imm;
  logic        do_write;

  assign opc = opcode_e'(instr_q[OPC_LSB +: REG_W]);
  assign rd  = instr_q[RD_LSB +: REG_W];
  assign ra  = instr_q[RA_LSB +: REG_W];
  assign rb  = instr_q[RB_LSB +: REG_W];
  assign imm = instr_q[IMM_LSB +: IMM_W];

  dp_ctrl_decode u_decode (
    .opcode_i (opc),
    .dec_o    (dec)
  );

  assign do_write = dec.legal && (opc != OP_NOP) && (rd != ZERO_REG);

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    w           = 1'b0;
    fs          = FS_ADD;
    s           = 1'b0;
    c0          = 1'b0;
    addrR       = '0;
    addrA       = '0;
    addrB       = '0;
    k           = '0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_DRIVE;
      end
      ST_DRIVE: state_d = do_write ? ST_WRITE : ST_IDLE;
      ST_WRITE: begin
        w       = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // DRIVE and WRITE present identical controls so nothing moves under w.
    if (state_q != ST_IDLE) begin
      fs    = dec.fs;
      s     = dec.s;
      c0    = dec.c0;
      addrR = rd;
      addrA = dec.force_a31 ? ZERO_REG : ra;
      addrB = rb;
      k     = 64'(imm);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && instr_valid) instr_q <= instr;
      if (state_q == ST_DRIVE && !dec.legal) illegal_q <= 1'b1;
    end
  end

`ifdef DP_CTRL_SEQ_FLAGS_EN
  logic [3:0] flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (state_q == ST_WRITE && dec.set_flags) begin
      flags_q <= status;
    end
  end

  assign flags = flags_q;
`else
  logic unused_status;

  assign unused_status = ^status;
  assign flags         = '0;
`endif

  assign busy    = (state_q != ST_IDLE);
  assign illegal = illegal_q;
  assign sd      = 1'b1;
  assign sb      = 1'b0;

endmodule

// File: tb/tb_dp_ctrl_seq.sv
// Directed bench for dp_ctrl_seq: a per-cycle timeline model plus literal
// expectations for the key scenarios.
module tb_dp_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [3:0]  status = '0;
  logic [4:0]  fs, addrR, addrA, addrB;
  logic [63:0] k;
  logic        s, sd, sb, c0, w, busy, illegal;
  logic [3:0]  flags;

  dp_ctrl_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .status(status), .fs(fs), .addrR(addrR), .addrA(addrA),
    .addrB(addrB), .k(k), .s(s), .sd(sd), .sb(sb), .c0(c0), .w(w),
    .busy(busy), .illegal(illegal), .flags(flags)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int w_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected cycle-by-cycle behaviour, one record per clock cycle.
  typedef struct packed {
    logic        idle, chk, w, set_ill, latch;
    logic [4:0]  fs;
    logic        s, c0;
    logic [4:0]  ar, aa, ab;
    logic [11:0] k;
  } rec_t;

  localparam rec_t IDLE_R = '{idle: 1'b1, chk: 1'b1, w: 1'b0, set_ill: 1'b0,
                              latch: 1'b0, fs: 5'b01000, s: 1'b0, c0: 1'b0,
                              ar: 5'd0, aa: 5'd0, ab: 5'd0, k: 12'd0};

  rec_t       exp_q[$];
  rec_t       cur;
  logic       ill_m = 1'b0;
  logic [3:0] flg_m = '0;
  logic       live = 1'b0;

  // {legal, set_flags, force_a31, c0, s, fs[4:0]} straight from the opcode table.
  function automatic logic [9:0] ref_ctl(input logic [4:0] op);
    case (op)
      5'd0:  return {5'b10000, 5'b01000};
      5'd1:  return {5'b10000, 5'b01000};
      5'd2:  return {5'b10010, 5'b01001};
      5'd3:  return {5'b10000, 5'b00000};
      5'd4:  return {5'b10000, 5'b00100};
      5'd5:  return {5'b10000, 5'b01100};
      5'd6:  return {5'b10001, 5'b01000};
      5'd7:  return {5'b10011, 5'b01001};
      5'd8:  return {5'b10001, 5'b10000};
      5'd9:  return {5'b10001, 5'b10100};
      5'd10: return {5'b10101, 5'b01000};
`ifdef DP_CTRL_SEQ_FLAGS_EN
      5'd11: return {5'b11000, 5'b01000};
      5'd12: return {5'b11010, 5'b01001};
`endif
      default: return {5'b00000, 5'b01000};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      ill_m = 1'b0;
      flg_m = '0;
      cur   = IDLE_R;
      live  = 1'b1;
    end else if (live) begin
      if (cur.set_ill) ill_m = 1'b1;
      if (cur.latch) flg_m = status;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
      end else if (cur.idle && instr_valid) begin
        logic [9:0] t;
        rec_t d, wr_r;
        logic [4:0] op, rd;
        op = instr[31:27];
        rd = instr[26:22];
        t  = ref_ctl(op);
        d.idle = 1'b0;
        d.chk = t[9] && (op != 5'd0);
        d.w = 1'b0;
        d.set_ill = !t[9];
        d.latch = 1'b0;
        d.fs = t[4:0];
        d.s = t[5];
        d.c0 = t[6];
        d.ar = rd;
        d.aa = t[7] ? 5'd31 : instr[21:17];
        d.ab = instr[16:12];
        d.k = instr[11:0];
        exp_q.push_back(d);
        if (t[9] && op != 5'd0 && rd != 5'd31) begin
          wr_r = d;
          wr_r.w = 1'b1;
          wr_r.latch = t[8];
          exp_q.push_back(wr_r);
        end
        cur = exp_q.pop_front();
      end else begin
        cur = IDLE_R;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("cyc_hs", {instr_ready, busy, w, sd, sb, illegal, flags},
          {cur.idle, !cur.idle, cur.w, 1'b1, 1'b0, ill_m, flg_m});
      if (cur.chk) begin
        chk("cyc_ctl", {fs, s, c0, addrR, addrA, addrB},
            {cur.fs, cur.s, cur.c0, cur.ar, cur.aa, cur.ab});
        chk("cyc_k", k, {52'd0, cur.k});
      end
      if (w === 1'b1) w_cyc.push_back(cyc);
    end
  end

  // Called at a falling edge; returns just after the accepting rising edge.
  task automatic send(input logic [31:0] ins, output int acc);
    logic rdy;
    int   c;
    acc = -1;
    instr_valid = 1'b1;
    instr = ins;
    for (int i = 0; i < 20; i++) begin
      rdy = instr_ready;
      c = cyc;
      @(posedge clk);
      if (rdy) begin
        acc = c;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int ra,
                                     input int rb, input int imm);
    return {5'(op), 5'(rd), 5'(ra), 5'(rb), 12'(imm)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_idle_ctl", {fs, s, c0, w, busy, illegal}, {5'b01000, 5'b00000});
    chk("rst_idle_k", k, 0);

    // MOVI rd=0 imm=916
    send(mk(10, 0, 7, 9, 916), t0);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("movi_drive", {instr_ready, w}, 2'b00);
    @(negedge clk);
    chk("movi_w", w, 1);
    chk("movi_addr", {addrR, addrA}, {5'd0, 5'd31});
    chk("movi_k", k, 916);
    chk("movi_fs_s", {fs, s}, {5'b01000, 1'b1});
    @(negedge clk);
    chk("movi_w_after", w, 0);

    // ADD then SUB back to back
    w_cyc.delete();
    send(mk(1, 20, 0, 1, 0), t0);
    @(negedge clk);
    send(mk(2, 21, 3, 5, 0), t1);
    chk("addsub_accept_gap", 64'(t1 - t0), 3);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("sub_fs_c0", {fs, c0}, {5'b01001, 1'b1});
    repeat (2) @(negedge clk);
    chk("addsub_w_count", 64'(w_cyc.size()), 2);
    if (w_cyc.size() == 2) chk("addsub_w_gap", 64'(w_cyc[1] - w_cyc[0]), 3);

    // LSLI rd=22 ra=5 imm=3, outputs identical in DRIVE and WRITE
    send(mk(8, 22, 5, 2, 3), t0);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int ph = 0; ph < 2; ph++) begin
      chk("lsli_ctl", {fs, s, addrA, addrR, w}, {5'b10000, 1'b1, 5'd5, 5'd22, 1'(ph)});
      chk("lsli_k", k, 3);
      @(negedge clk);
    end

    // Illegal opcode 31, ADD to rd=31, then a normal ADD
    w_cyc.delete();
    send(mk(31, 3, 1, 2, 0), t0);
    @(negedge clk);
    send(mk(1, 31, 1, 2, 0), t1);
    chk("illegal_gap", 64'(t1 - t0), 2);
    chk("illegal_set", illegal, 1);
    @(negedge clk);
    send(mk(1, 5, 1, 2, 0), t2);
    chk("zero_reg_gap", 64'(t2 - t1), 2);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("illegal_w_count", 64'(w_cyc.size()), 1);
    chk("illegal_sticky", illegal, 1);

    // Reset during DRIVE of an ADD
    w_cyc.delete();
    send(mk(1, 4, 1, 2, 77), t0);
    @(negedge clk);
    instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle", {w, fs, addrR, illegal}, {1'b0, 5'b01000, 5'd0, 1'b0});
    chk("abort_k", k, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", instr_ready, 1);
    repeat (2) @(negedge clk);
    chk("abort_no_w", 64'(w_cyc.size()), 0);

    // SUBS rd=2 with status 0001
    w_cyc.delete();
    status = 4'b0001;
    send(mk(12, 2, 1, 3, 0), t0);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
`ifdef DP_CTRL_SEQ_FLAGS_EN
    chk("subs_flags", flags, 4'b0001);
    chk("subs_w_count", 64'(w_cyc.size()), 1);
`else
    chk("subs_illegal", illegal, 1);
    chk("subs_w_count", 64'(w_cyc.size()), 0);
`endif

    // Sweep every 5-bit opcode with instr_valid held high throughout
    for (int op = 0; op < 32; op++) begin
      status = 4'(op * 5);
      send(mk(op, (op == 9) ? 31 : op + 1, op + 3, 30 - op, op * 257), t0);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
